// File: rtl/osecpu_pkg.sv
// Shared OSECPU definitions: fetch state encoding, opcodes and the
// opcode-to-instruction-length rule.
package osecpu_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   localparam logic [7:0] OP_HLT     = 8'hFF;
   localparam logic [7:0] OP_LIMM    = 8'h01;
   localparam logic [7:0] OP_DATA    = 8'hD0;
   localparam logic [7:0] OP_ILLEGAL = 8'h00;

   // Instruction length in words; 0 marks an opcode that can never execute.
   function automatic logic [7:0] op_len(input logic [7:0] opcode);
      case (opcode)
         OP_LIMM, OP_DATA: op_len = 8'd2;
         OP_ILLEGAL:       op_len = 8'd0;
         default:          op_len = 8'd1;
      endcase
   endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Length decode for the first word of an instruction; flags lengths the
// sequencer cannot hold (zero or longer than its word buffer).
module fetch_len_decode
   import osecpu_pkg::*;
#(
   parameter int MAX_WORDS = 4,
   parameter int LEN_W     = 3
) (
   input  logic [7:0]       opcode_i,
   output logic [LEN_W-1:0] len_o,
   output logic             illegal_o
);

   localparam logic [7:0] MAXW = 8'(MAX_WORDS);

   logic [7:0] raw_len;

   assign raw_len   = op_len(opcode_i);
   assign illegal_o = (raw_len == 8'd0) || (raw_len > MAXW);
   assign len_o     = LEN_W'(raw_len);

endmodule

// File: rtl/fetch_sequencer.sv
// Variable-length instruction fetch/sequence controller: assembles
// 1..MAX_WORDS words from a wait-state memory port, hands the instruction
// to execute with a valid/done handshake, and applies jumps and halt/resume.
module fetch_sequencer
   import osecpu_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                WORD_W    = 32,
   parameter int                MAX_WORDS = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   localparam int LEN_W = ($clog2(MAX_WORDS + 1) < 3) ? 3 : $clog2(MAX_WORDS + 1),
   localparam int IDX_W = $clog2(MAX_WORDS)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   output logic                        mem_req,
   output logic [ADDR_W-1:0]           mem_addr,
   input  logic                        mem_ack,
   input  logic [WORD_W-1:0]           mem_rdata,
   output logic [MAX_WORDS*WORD_W-1:0] instr,
   output logic [LEN_W-1:0]            instr_len,
   output logic                        instr_valid,
   input  logic                        exec_done,
   input  logic                        jmp_valid,
   input  logic [ADDR_W-1:0]           jmp_addr,
   input  logic                        resume,
   output logic                        halted,
   output logic                        fault,
   output logic [ADDR_W-1:0]           pc,
   output logic [1:0]                  state
);

   fetch_state_e                         state_q, state_d;
   logic [ADDR_W-1:0]                    pc_q, pc_d;
   logic [MAX_WORDS-1:0][WORD_W-1:0]     words_q, words_d;
   logic [LEN_W-1:0]                     len_q, len_d;
   logic [IDX_W-1:0]                     idx_q, idx_d;
   logic                                 fault_q, fault_d;

   logic [LEN_W-1:0]                     dec_len;
   logic                                 dec_illegal;
   logic [LEN_W-1:0]                     cur_len;
   logic [7:0]                           exec_op;

   fetch_len_decode #(
      .MAX_WORDS (MAX_WORDS),
      .LEN_W     (LEN_W)
   ) u_len_decode (
      .opcode_i  (mem_rdata[WORD_W-1 -: 8]),
      .len_o     (dec_len),
      .illegal_o (dec_illegal)
   );

   // First word decides the length; later words use the stored one.
   assign cur_len = (idx_q == '0) ? dec_len : len_q;
   assign exec_op = words_q[0][WORD_W-1 -: 8];

   // Next-state logic for the fetch/exec/halt sequence.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      words_d = words_q;
      len_d   = len_q;
      idx_d   = idx_q;
      fault_d = fault_q;
      unique case (state_q)
         ST_FETCH: begin
            if (mem_ack) begin
               pc_d = pc_q + ADDR_W'(1);
               if (idx_q == '0) begin
                  words_d = '0;
                  len_d   = dec_len;
               end
               for (int w = 0; w < MAX_WORDS; w++) begin
                  if (idx_q == IDX_W'(w)) words_d[w] = mem_rdata;
               end
               if ((idx_q == '0) && dec_illegal) begin
                  state_d = ST_HALT;
                  fault_d = 1'b1;
               end else if (LEN_W'(idx_q) == cur_len - LEN_W'(1)) begin
                  state_d = ST_EXEC;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               // A halt never branches, even with jmp_valid set.
               if (exec_op == OP_HLT) begin
                  state_d = ST_HALT;
               end else begin
                  if (jmp_valid) pc_d = jmp_addr;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            if (resume) begin
               fault_d = 1'b0;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         words_q <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         words_q <= words_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         fault_q <= fault_d;
      end
   end

   assign mem_req     = reset_n && (state_q == ST_FETCH);
   assign mem_addr    = pc_q;
   assign instr       = words_q;
   assign instr_len   = len_q;
   assign instr_valid = (state_q == ST_EXEC);
   assign halted      = (state_q == ST_HALT);
   assign fault       = fault_q;
   assign pc          = pc_q;
   assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed walk through the main scenarios, then
// a randomized run against a program-level reference model with a scoreboard.
module tb_fetch_sequencer;

   localparam int AW = 16;
   localparam int WW = 32;
   localparam int MW = 4;
   localparam int LW = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              mem_req;
   logic [AW-1:0]     mem_addr;
   logic              mem_ack;
   logic [WW-1:0]     mem_rdata;
   logic [MW*WW-1:0]  instr;
   logic [LW-1:0]     instr_len;
   logic              instr_valid;
   logic              exec_done;
   logic              jmp_valid;
   logic [AW-1:0]     jmp_addr;
   logic              resume;
   logic              halted;
   logic              fault;
   logic [AW-1:0]     pc;
   logic [1:0]        state;

   logic [31:0] mem [0:65535];
   assign mem_rdata = mem[mem_addr];

   fetch_sequencer #(.ADDR_W(AW), .WORD_W(WW), .MAX_WORDS(MW), .RESET_PC('0)) dut (
      .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_len(instr_len),
      .instr_valid(instr_valid), .exec_done(exec_done), .jmp_valid(jmp_valid),
      .jmp_addr(jmp_addr), .resume(resume), .halted(halted), .fault(fault),
      .pc(pc), .state(state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected event: either a presented instruction or entry into HALT.
   typedef struct {
      bit           halt;
      bit           flt;
      logic [127:0] ins;
      logic [2:0]   len;
      logic [15:0]  pc;
      logic [7:0]   op;
   } exp_t;

   exp_t q[$];

   // Reference model: what happens when fetching starts at address p.
   function automatic exp_t predict(input logic [15:0] p);
      exp_t e;
      logic [31:0] w0;
      int L;
      w0 = mem[p];
      e.op = w0[31:24];
      L = (e.op == 8'h01 || e.op == 8'hD0) ? 2 : ((e.op == 8'h00) ? 0 : 1);
      e.ins = '0;
      e.len = 3'(L);
      if (L == 0) begin
         e.halt = 1'b1;
         e.flt  = 1'b1;
         e.pc   = p + 16'd1;
      end else begin
         e.halt = 1'b0;
         e.flt  = 1'b0;
         for (int k = 0; k < L; k++) e.ins[k*32 +: 32] = mem[16'(p + k)];
         e.pc = 16'(p + L);
      end
      return e;
   endfunction

   // Memory ack responder: 0 = driven by the directed sequence, 1 = always, 2 = random.
   int ack_mode = 0;
   always @(negedge clk) begin
      if (ack_mode == 2) mem_ack = ($urandom_range(0, 9) < 6);
      else if (ack_mode == 1) mem_ack = 1'b1;
   end

   // Scoreboard monitor: compare on each rising instr_valid / halted.
   bit   mon_en = 1'b0;
   logic pv = 1'b0, ph = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && reset_n && ((instr_valid && !pv) || (halted && !ph))) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: unexpected output in state %0d pc %0h", state, pc);
         end else begin
            e = q.pop_front();
            chk("sb_halted", halted, e.halt);
            chk("sb_pc", pc, e.pc);
            if (e.halt) chk("sb_fault", fault, e.flt);
            else begin
               chk("sb_instr", instr, e.ins);
               chk("sb_len", instr_len, e.len);
            end
         end
      end
      pv = instr_valid;
      ph = halted;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        cur;
      logic        do_j;
      logic [15:0] ja;
      int          k;

      reset_n = 1'b0; mem_ack = 1'b1; exec_done = 1'b0; jmp_valid = 1'b0;
      jmp_addr = '0; resume = 1'b0;
      mem[0] = 32'h01000005; mem[1] = 32'h0000002A; mem[2] = 32'hFF000000;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_state", state, 2'd0);
      chk("rst_pc", pc, 16'h0);
      chk("rst_instr", instr, '0);
      chk("rst_len", instr_len, 3'd0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_fault", fault, 1'b0);

      // Basic 2-word + HLT program with ack tied high
      reset_n = 1'b1;
      #1;
      chk("b_req0", mem_req, 1'b1);
      chk("b_addr0", mem_addr, 16'h0);
      @(negedge clk);
      chk("b_addr1", mem_addr, 16'h1);
      chk("b_nvalid", instr_valid, 1'b0);
      @(negedge clk);
      chk("b_valid", instr_valid, 1'b1);
      chk("b_len", instr_len, 3'd2);
      chk("b_w0", instr[31:0], 32'h01000005);
      chk("b_w1", instr[63:32], 32'h2A);
      chk("b_pc", pc, 16'h2);
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      chk("b_addr2", mem_addr, 16'h2);
      chk("b_req2", mem_req, 1'b1);
      @(negedge clk);
      chk("b_hlt_valid", instr_valid, 1'b1);
      chk("b_hlt_len", instr_len, 3'd1);
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      chk("b_halted", halted, 1'b1);
      chk("b_halt_pc", pc, 16'h3);
      chk("b_halt_req", mem_req, 1'b0);

      // Wait states: ack on every third cycle
      reset_n = 1'b0; mem_ack = 1'b0;
      mem[0] = 32'h01000007; mem[1] = 32'h00000011;
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         mem_ack = ((c % 3) == 2);
         chk("ws_addr", mem_addr, (c < 3) ? 16'd0 : 16'd1);
         chk("ws_pc", pc, (c < 3) ? 16'd0 : 16'd1);
         chk("ws_nvalid", instr_valid, 1'b0);
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk("ws_valid", instr_valid, 1'b1);
      chk("ws_w1", instr[63:32], 32'h11);
      chk("ws_pc2", pc, 16'h2);

      // Jump, then a jump request on HLT that must be ignored
      mem[16'h100] = 32'hFF000000;
      mem_ack = 1'b1; exec_done = 1'b1; jmp_valid = 1'b1; jmp_addr = 16'h0100;
      @(negedge clk);
      exec_done = 1'b0; jmp_valid = 1'b0;
      chk("j_addr", mem_addr, 16'h0100);
      chk("j_state", state, 2'd0);
      @(negedge clk);
      chk("j_hlt_valid", instr_valid, 1'b1);
      exec_done = 1'b1; jmp_valid = 1'b1; jmp_addr = 16'h0200;
      @(negedge clk);
      exec_done = 1'b0; jmp_valid = 1'b0;
      chk("j_halted", halted, 1'b1);
      chk("j_halt_pc", pc, 16'h0101);

      // Illegal opcode at 5, then resume
      mem[16'h101] = 32'h02000000; mem[5] = 32'h00000000; mem[6] = 32'h03000000;
      mem[16'hFFFF] = 32'h04000000;
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      chk("r_addr", mem_addr, 16'h0101);
      @(negedge clk);
      chk("r_valid", instr_valid, 1'b1);
      exec_done = 1'b1; jmp_valid = 1'b1; jmp_addr = 16'h0005;
      @(negedge clk);
      exec_done = 1'b0; jmp_valid = 1'b0;
      chk("il_addr", mem_addr, 16'h5);
      @(negedge clk);
      chk("il_halted", halted, 1'b1);
      chk("il_fault", fault, 1'b1);
      chk("il_pc", pc, 16'h6);
      chk("il_req", mem_req, 1'b0);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      chk("il_fault_clr", fault, 1'b0);
      chk("il_req2", mem_req, 1'b1);
      chk("il_addr6", mem_addr, 16'h6);

      // PC wrap at 0xFFFF
      @(negedge clk);
      chk("w_valid", instr_valid, 1'b1);
      exec_done = 1'b1; jmp_valid = 1'b1; jmp_addr = 16'hFFFF;
      @(negedge clk);
      exec_done = 1'b0; jmp_valid = 1'b0;
      chk("w_addr", mem_addr, 16'hFFFF);
      @(negedge clk);
      chk("w_valid2", instr_valid, 1'b1);
      chk("w_pc", pc, 16'h0000);

      // Reset in the middle of a 2-word fetch
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      chk("mr_addr", mem_addr, 16'h0);
      @(negedge clk);
      chk("mr_pc_mid", pc, 16'h1);
      reset_n = 1'b0;
      #1;
      chk("mr_req_rst", mem_req, 1'b0);
      @(negedge clk);
      chk("mr_pc", pc, 16'h0);
      chk("mr_instr", instr, '0);
      chk("mr_len", instr_len, 3'd0);
      chk("mr_state", state, 2'd0);
      chk("mr_req", mem_req, 1'b0);

      // Randomized program run against the reference model
      mem_ack = 1'b0;
      for (int a = 0; a < 65536; a++) begin
         logic [7:0] op;
         int r;
         r = $urandom_range(0, 9);
         op = (r < 3) ? 8'h01 : (r == 3) ? 8'hD0 : (r == 4) ? 8'hFF :
              (r == 5) ? 8'h00 : 8'($urandom_range(0, 255));
         mem[a] = {op, 24'($urandom)};
      end
      q.delete();
      cur = predict(16'h0);
      q.push_back(cur);
      mon_en = 1'b1;
      ack_mode = 2;
      reset_n = 1'b1;
      for (int it = 0; it < 200; it++) begin
         if ((it % 50) == 25) ack_mode = 3 - ack_mode;
         k = 0;
         while (!(instr_valid || halted) && k < 300) begin
            @(negedge clk);
            k++;
         end
         if (!(instr_valid || halted)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no instruction or halt, state %0d pc %0h", state, pc);
            break;
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (cur.halt) begin
            resume = 1'b1;
            cur = predict(cur.pc);
            q.push_back(cur);
            @(negedge clk);
            resume = 1'b0;
         end else begin
            do_j = ($urandom_range(0, 2) == 0);
            ja = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 1))
                                             : 16'($urandom_range(0, 65535));
            exec_done = 1'b1; jmp_valid = do_j; jmp_addr = ja;
            if (cur.op == 8'hFF) begin
               cur.halt = 1'b1;
               cur.flt  = 1'b0;
            end else begin
               cur = predict(do_j ? ja : cur.pc);
            end
            q.push_back(cur);
            @(negedge clk);
            exec_done = 1'b0; jmp_valid = 1'b0;
         end
      end
      k = 0;
      while (q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("sb_drain", 128'(q.size()), 128'd0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised instruction fetch/sequence controller for the OSECPU core: the successor of the fixed 16-bit, fixed two-word fetch controller. It fetches variable-length instructions (1..MAX_WORDS words) over a request/acknowledge memory port that tolerates wait states. It presents each complete instruction to the execute stage with a valid/done handshake, and applies jumps and halt/resume. It sits between instruction memory and the execute/register stage.

## Interface
Parameters:
- ADDR_W, 16, width of pc and memory address
- WORD_W, 32, instruction word width; opcode is bits [WORD_W-1:WORD_W-8]
- MAX_WORDS, 4, longest instruction in words (≥2)
- RESET_PC, 0, pc value after reset

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  reset, synchronous, active-low
- mem_req  out  1  fetch request; address valid while high
- mem_addr  out  ADDR_W  fetch address (= pc while mem_req)
- mem_ack  in  1  read data valid this cycle; completes current request
- mem_rdata  in  WORD_W  read data, sampled only when mem_req && mem_ack
- instr  out  MAX_WORDS*WORD_W  assembled instruction; word 0 in LSBs; unused words zero
- instr_len  out  3+  number of valid words (1..MAX_WORDS)
- instr_valid  out  1  instruction ready for execute stage
- exec_done  in  1  execute stage has finished the presented instruction
- jmp_valid  in  1  qualifies jmp_addr; sampled only with exec_done
- jmp_addr  in  ADDR_W  branch target
- resume  in  1  leave HALT
- halted  out  1  in HALT state
- fault  out  1  halted because of an illegal length
- pc  out  ADDR_W  address of next word to fetch
- state  out  2  current state (debug)

## Operation
- States: FETCH, EXEC, HALT.
- Reset (reset_n=0 at posedge): state=FETCH, pc=RESET_PC, instr=0, instr_len=0, word index=0, fault=0. mem_req is forced low while reset_n=0. instr_valid=0 and halted=0 follow from state.
- FETCH: mem_req=1, mem_addr=pc. On mem_ack:
  - store mem_rdata into word[idx]; pc<=pc+1 (wraps 2^ADDR_W-1 → 0).
  - If idx==0: length L = op_len(opcode of mem_rdata); clear words 1..MAX_WORDS-1; instr_len<=L.
  - If L==0 or L>MAX_WORDS: go to HALT with fault=1.
  - If idx==L-1: go to EXEC with idx<=0. Otherwise idx<=idx+1.
  - With no ack, hold all state.
- EXEC: instr_valid=1, instr stable. On exec_done:
  - Opcode OP_HLT: go to HALT; jmp_valid is ignored.
  - Else if jmp_valid: pc<=jmp_addr; go to FETCH.
  - Else go to FETCH.
- HALT: halted=1, mem_req=0. On resume: fault<=0; go to FETCH at the current pc, which is the address after HLT.
- Ignored inputs: mem_ack outside FETCH; exec_done outside EXEC; resume outside HALT.
- Reset has priority over every event, including mid-instruction and while halted.

## Timing
- One word per cycle when mem_ack is tied high.
- A 1-word instruction takes 1 FETCH cycle, then EXEC from the next cycle.
- Instruction latency = sum over its words of (wait cycles + 1); instr_valid rises the cycle after the last ack.
- exec_done in the first EXEC cycle gives a 1-cycle EXEC; mem_req reasserts the following cycle at the new pc.
- Registered outputs: pc, instr, instr_len, fault, state.
- Decoded from state (no added latency): mem_req, instr_valid, halted.

## Structure
- Shared package osecpu_pkg holds:
  - state encoding constants
  - opcode constants: OP_HLT = 8'hFF, OP_LIMM = 8'h01, OP_DATA = 8'hD0
  - op_len(opcode) function: 01→2, D0→2, 00→0 (illegal), all others→1
- One sub-module, fetch_len_decode: wraps op_len plus the MAX_WORDS legality check. Outputs len and illegal.

## Test plan
- Reset, mem_ack=1, memory [0x01000005, 0x0000002A, 0xFF000000]:
  - mem_addr 0 then 1;
  - instr_valid after 2 cycles with instr_len=2, word1=0x2A;
  - exec_done → fetch from addr 2;
  - HLT → halted=1, pc=3, mem_req=0.
- Wait states: ack only every 3rd cycle on a 2-word op. mem_addr must hold at each address until its ack; instr_valid exactly 1 cycle after the 2nd ack; pc increments only on ack.
- Jump: exec_done with jmp_valid=1, jmp_addr=0x0100 → next mem_addr=0x0100. Repeat on an HLT op with jmp_valid=1 → HALT, pc unchanged.
- Illegal opcode 0x00 at addr 5 → halted=1, fault=1, pc=6. Pulse resume → fault=0, fetch resumes at addr 6.
- Wrap and reset:
  - pc=0xFFFF 1-word op → pc becomes 0x0000.
  - reset_n=0 in the middle of a 2-word fetch → next cycle pc=RESET_PC, instr=0, mem_req=0 while in reset.
